song_player: RTL and testbench

Playback engine for the stored song: the read-side counterpart to the song editor. On a start request in play mode it snapshots the editor's two packed note words and the song length, then steps through the notes at a fixed tempo. Each note is presented on a 2-bit code output, a one-hot lane output and a one-cycle strobe, and a done pulse is raised at the end. It sits between the song editor's note registers and the lane LEDs / game-scoring logic.

---
 rtl/song_player.sv | 149 ++++++++++++++
 tb/tb_song_player.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// Playback engine: snapshots the editor's packed note words and length on start,
// then steps through the notes at a fixed tempo with registered outputs.
module song_player #(
  parameter int TICKS_PER_NOTE = 10_000_000,
  parameter int MAX_NOTES      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode,
  input  logic        start,
  input  logic        pause,
  input  logic [31:0] note1,
  input  logic [31:0] note2,
  input  logic [5:0]  length,
  output logic [1:0]  note_out,
  output logic [3:0]  lane,
  output logic        note_strobe,
  output logic [4:0]  position,
  output logic        playing,
  output logic        done
);

  localparam int CW = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_NOTE - 1);
  localparam logic [5:0]    MAX_LEN   = 6'(MAX_NOTES);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   n1_q, n2_q;
  logic [5:0]    len_q;
  logic [5:0]    len_eff;
  logic          run_mode, start_go, start_zero, abort, terminal, last_note;
  logic [1:0]    note_d;
  logic [3:0]    lane_d;
  logic [4:0]    pos_d;
  logic          strobe_d, playing_d, done_d;

  // Notes 0-15 live in the low word, 16-31 in the high word, two bits each.
  function automatic logic [1:0] pick(input logic [31:0] lo, input logic [31:0] hi,
                                      input logic [4:0] idx);
    logic [63:0] w;
    w = {hi, lo};
    return w[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] code);
    case (code)
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  assign len_eff    = (length > MAX_LEN) ? MAX_LEN : length;
  assign run_mode   = (mode == 3'd3);
  assign start_go   = (state_q == IDLE) && start && run_mode && (len_eff != 6'd0);
  assign start_zero = (state_q == IDLE) && start && run_mode && (len_eff == 6'd0);
  assign abort      = (state_q == PLAY) && !run_mode;
  assign terminal   = (state_q == PLAY) && !pause && (cnt_q == LAST_TICK);
  assign last_note  = ({1'b0, position} == (len_q - 6'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n1_q        <= '0;
      n2_q        <= '0;
      len_q       <= '0;
      note_out    <= '0;
      lane        <= '0;
      note_strobe <= 1'b0;
      position    <= '0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      note_out    <= note_d;
      lane        <= lane_d;
      note_strobe <= strobe_d;
      position    <= pos_d;
      playing     <= playing_d;
      done        <= done_d;
      if (start_go) begin
        n1_q  <= note1;
        n2_q  <= note2;
        len_q <= len_eff;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_go) state_d = PLAY;
      PLAY: begin
        // Abort wins over a terminal count landing in the same cycle.
        if (abort)                       state_d = IDLE;
        else if (terminal && last_note)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    note_d    = 2'd0;
    strobe_d  = 1'b0;
    pos_d     = 5'd0;
    playing_d = 1'b0;
    done_d    = 1'b0;
    cnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          playing_d = 1'b1;
          strobe_d  = 1'b1;
          note_d    = pick(note1, note2, 5'd0);
        end else if (start_zero) begin
          done_d = 1'b1;
        end
      end
      PLAY: begin
        if (abort) begin
          playing_d = 1'b0;
        end else if (terminal) begin
          if (last_note) begin
            done_d = 1'b1;
          end else begin
            playing_d = 1'b1;
            strobe_d  = 1'b1;
            pos_d     = position + 5'd1;
            note_d    = pick(n1_q, n2_q, position + 5'd1);
          end
        end else begin
          playing_d = 1'b1;
          pos_d     = position;
          note_d    = note_out;
          cnt_d     = pause ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    lane_d = one_hot(note_d);
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 4-cycle tempo; each scenario task
// drives its stimulus and compares the full output vector cycle by cycle.
module tb_song_player;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        start, pause;
  logic [31:0] note1, note2;
  logic [5:0]  length;
  logic [1:0]  note_out;
  logic [3:0]  lane;
  logic        note_strobe, playing, done;
  logic [4:0]  position;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0]  lane_tab [4] = '{4'b0000, 4'b0010, 4'b0100, 4'b1000};
  logic [13:0] obs, exp_v;

  assign obs = {playing, note_strobe, position, note_out, lane, done};

  song_player #(.TICKS_PER_NOTE(T), .MAX_NOTES(32)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .pause(pause),
    .note1(note1), .note2(note2), .length(length),
    .note_out(note_out), .lane(lane), .note_strobe(note_strobe),
    .position(position), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 3'd0; start = 1'b0; pause = 1'b0;
    note1 = '0; note2 = '0; length = '0;
    tick(2);
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_state got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    rst = 1'b0;
    tick(1);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_release got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  // variant 0: plain play, 1: inputs change mid-play, 2: start pulsed mid-play
  task automatic test_sequence(input string name, input int variant);
    mode = 3'd3; note1 = 32'h0000_00E4; note2 = '0; length = 6'd4; pause = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_v = {1'b1, (i % 4 == 0), 5'(i / 4), 2'(i / 4), lane_tab[i / 4], 1'b0};
      else if (i == 16) exp_v = 14'b1;
      else exp_v = '0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, obs, exp_v);
      else pass_cnt++;
      if (variant == 1 && i == 2) begin note1 = '0; length = 6'd1; end
      start = (variant == 2 && i == 5);
      tick(1);
    end
    start = 1'b0;
  endtask

  task automatic test_crossover();
    int pos, code;
    mode = 3'd3; note1 = 32'hFFFF_FFFF; note2 = 32'h5555_5555; length = 6'd40; pause = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      pos  = i / 4;
      code = (pos < 16) ? 3 : 1;
      if (i < 128) exp_v = {1'b1, (i % 4 == 0), 5'(pos), 2'(code), lane_tab[code], 1'b0};
      else if (i == 128) exp_v = 14'b1;
      else exp_v = '0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL crossover cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
      tick(1);
    end
  endtask

  task automatic test_pause();
    int k;
    logic s;
    mode = 3'd3; note1 = 32'h0000_00E4; note2 = '0; length = 6'd4; pause = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 23; i++) begin
      k = (i >= 17) ? 3 : (i >= 13) ? 2 : (i >= 4) ? 1 : 0;
      s = (i == 0 || i == 4 || i == 13 || i == 17);
      if (i < 21) exp_v = {1'b1, s, 5'(k), 2'(k), lane_tab[k], 1'b0};
      else if (i == 21) exp_v = 14'b1;
      else exp_v = '0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
      pause = (i >= 5 && i < 10);
      tick(1);
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    mode = 3'd3; note1 = 32'h0000_00E4; note2 = '0; length = 6'd4; pause = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) exp_v = {1'b1, (i % 4 == 0), 5'(i / 4), 2'(i / 4), lane_tab[i / 4], 1'b0};
      else exp_v = '0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
      if (i == 9) mode = 3'd2;
      tick(1);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_v = '0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL wrong_mode_start cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
      tick(1);
    end
    mode = 3'd3;
  endtask

  task automatic test_zero_length();
    mode = 3'd3; length = 6'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_v = 14'b1;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zero_len_done got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    tick(1);
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zero_len_after got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mode = 3'd3; note1 = 32'h0000_00E4; length = 6'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    exp_v = {1'b1, 1'b0, 5'd1, 2'd1, 4'b0010, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_mid_pre got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    rst = 1'b1;
    tick(1);
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_mid got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic playing_e, strobe_e, done_e;
    mode = 3'd3; note1 = 32'h0000_0003; note2 = '0; length = 6'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      playing_e = (i < 4) || (i >= 5 && i < 9);
      strobe_e  = (i == 0 || i == 5);
      done_e    = (i == 4 || i == 9);
      exp_v = {playing_e, strobe_e, 5'd0, playing_e ? 2'd3 : 2'd0,
               playing_e ? 4'b1000 : 4'b0000, done_e};
      total_cnt++;
      if (obs !== exp_v) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs, exp_v);
      else pass_cnt++;
      start = (i == 4);
      tick(1);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence("basic", 0);
    tick(2);
    test_crossover();
    tick(2);
    test_sequence("snapshot", 1);
    tick(2);
    test_pause();
    tick(2);
    test_abort();
    tick(2);
    test_sequence("start_in_play", 2);
    tick(2);
    test_zero_length();
    tick(2);
    test_reset_mid();
    tick(2);
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
